// File: rtl/dds_pkg.sv
// Shared encodings for the DDS sweep controller and the dds block:
// sweep modes, sweep FSM states and wave-type selectors.
package dds_pkg;

  typedef enum logic [1:0] {
    SWEEP_SINGLE   = 2'b00,
    SWEEP_REPEAT   = 2'b01,
    SWEEP_PINGPONG = 2'b10,
    SWEEP_RSVD     = 2'b11
  } sweep_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } sweep_state_e;

  localparam logic [1:0] WAVE_SINE     = 2'b00;
  localparam logic [1:0] WAVE_TRIANGLE = 2'b01;
  localparam logic [1:0] WAVE_SQUARE   = 2'b10;

  // The reserved encoding behaves as a single up-sweep.
  function automatic sweep_mode_e norm_mode(input logic [1:0] m);
    return (m == 2'b11) ? SWEEP_SINGLE : sweep_mode_e'(m);
  endfunction

endpackage

// File: rtl/dds_sweep_ctrl_if.sv
// Host-side bundle of the sweep controller. sweep_cnt exists only when
// DDS_SWEEP_CNT_EN is defined; state is a debug view of the sweep FSM.
interface dds_sweep_ctrl_if #(
  parameter int PHASE_WIDTH = 32,
  parameter int DWELL_WIDTH = 32
);
  import dds_pkg::*;

  // start/abort are single-cycle pulses with no ready: start is taken only
  // while the controller is IDLE (otherwise dropped), abort always wins.
  logic                   start;
  logic                   abort;
  logic [1:0]             mode;
  logic [PHASE_WIDTH-1:0] f_start;
  logic [PHASE_WIDTH-1:0] f_stop;
  logic [PHASE_WIDTH-1:0] f_step;
  logic [DWELL_WIDTH-1:0] dwell;
  logic [PHASE_WIDTH-1:0] fre_word;
  logic                   dds_en;
  logic                   busy;
  logic                   step_strobe;
  logic                   done;
  sweep_state_e           state;
`ifdef DDS_SWEEP_CNT_EN
  logic [15:0]            sweep_cnt;

  modport master (output start, abort, mode, f_start, f_stop, f_step, dwell,
                  input  fre_word, dds_en, busy, step_strobe, done, state, sweep_cnt);
  modport slave  (input  start, abort, mode, f_start, f_stop, f_step, dwell,
                  output fre_word, dds_en, busy, step_strobe, done, state, sweep_cnt);
`else
  modport master (output start, abort, mode, f_start, f_stop, f_step, dwell,
                  input  fre_word, dds_en, busy, step_strobe, done, state);
  modport slave  (input  start, abort, mode, f_start, f_stop, f_step, dwell,
                  output fre_word, dds_en, busy, step_strobe, done, state);
`endif
endinterface

// File: rtl/dds_dwell_timer.sv
// Dwell down-counter: load takes max(dwell,1); expire is high on the last
// cycle of the dwell and stays high until the next load.
module dds_dwell_timer #(
  parameter int DWELL_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic                   load,
  input  logic [DWELL_WIDTH-1:0] dwell,
  output logic                   expire
);
  logic [DWELL_WIDTH-1:0] cnt;

  always_ff @(posedge clock) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= (dwell == '0) ? DWELL_WIDTH'(1) : dwell;
    end else if (cnt > DWELL_WIDTH'(1)) begin
      cnt <= cnt - DWELL_WIDTH'(1);
    end
  end

  assign expire = (cnt == DWELL_WIDTH'(1));
endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer driving the DDS frequency word and enable.
// Optional sweep pass counter enabled by DDS_SWEEP_CNT_EN.
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int PHASE_WIDTH = 32,
  parameter int DWELL_WIDTH = 32
) (
  input  logic           clock,
  input  logic           rst,
  dds_sweep_ctrl_if.slave bus
);
  localparam int PW = PHASE_WIDTH;

  sweep_state_e           state, state_n;
  sweep_mode_e            cfg_mode;
  logic [PW-1:0]          cfg_start, cfg_stop, cfg_step;
  logic [DWELL_WIDTH-1:0] cfg_dwell, tmr_dwell;
  logic [PW-1:0]          fre_q, fre_n, up_val, down_val;
  logic [PW:0]            sum, diff;
  logic                   dir_down, dir_n, strobe_q, strobe_n;
  logic                   cfg_load, tmr_load, expire;
  logic                   at_stop, at_start, degenerate;

  // Steps are computed one bit wider so carry/borrow clamp to the range ends.
  assign sum        = {1'b0, fre_q} + {1'b0, cfg_step};
  assign diff       = {1'b0, fre_q} - {1'b0, cfg_step};
  assign up_val     = (cfg_step == '0 || sum[PW] || sum[PW-1:0] >= cfg_stop)
                      ? cfg_stop : sum[PW-1:0];
  assign down_val   = (cfg_step == '0 || diff[PW] || diff[PW-1:0] <= cfg_start)
                      ? cfg_start : diff[PW-1:0];
  assign at_stop    = (fre_q == cfg_stop);
  assign at_start   = (fre_q == cfg_start);
  assign degenerate = (cfg_stop <= cfg_start);
  assign tmr_dwell  = cfg_load ? bus.dwell : cfg_dwell;

  dds_dwell_timer #(.DWELL_WIDTH(DWELL_WIDTH)) u_timer (
    .clock  (clock),
    .rst    (rst),
    .load   (tmr_load),
    .dwell  (tmr_dwell),
    .expire (expire)
  );

  always_comb begin
    state_n  = state;
    fre_n    = fre_q;
    dir_n    = dir_down;
    strobe_n = 1'b0;
    cfg_load = 1'b0;
    tmr_load = 1'b0;
    unique case (state)
      IDLE: if (bus.start && !bus.abort) begin
        state_n  = RUN;
        cfg_load = 1'b1;
        fre_n    = bus.f_start;
        dir_n    = 1'b0;
        strobe_n = 1'b1;
        tmr_load = 1'b1;
      end
      RUN: if (bus.abort) begin
        state_n = IDLE;
      end else if (expire) begin
        strobe_n = 1'b1;
        tmr_load = 1'b1;
        if (degenerate) begin
          fre_n = cfg_start;
          if (cfg_mode == SWEEP_SINGLE) state_n = DONE;
        end else if (!dir_down) begin
          if (!at_stop) begin
            fre_n = up_val;
          end else if (cfg_mode == SWEEP_REPEAT) begin
            fre_n = cfg_start;
          end else if (cfg_mode == SWEEP_PINGPONG) begin
            dir_n = 1'b1;
            fre_n = down_val;
          end else begin
            state_n = DONE;
          end
        end else if (at_start) begin
          dir_n = 1'b0;
          fre_n = up_val;
        end else begin
          fre_n = down_val;
        end
        // Leaving for DONE is not a new frequency.
        if (state_n == DONE) begin
          strobe_n = 1'b0;
          tmr_load = 1'b0;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state     <= IDLE;
      fre_q     <= '0;
      dir_down  <= 1'b0;
      strobe_q  <= 1'b0;
      cfg_mode  <= SWEEP_SINGLE;
      cfg_start <= '0;
      cfg_stop  <= '0;
      cfg_step  <= '0;
      cfg_dwell <= '0;
    end else begin
      state    <= state_n;
      fre_q    <= fre_n;
      dir_down <= dir_n;
      strobe_q <= strobe_n;
      if (cfg_load) begin
        cfg_mode  <= norm_mode(bus.mode);
        cfg_start <= bus.f_start;
        cfg_stop  <= bus.f_stop;
        cfg_step  <= bus.f_step;
        cfg_dwell <= bus.dwell;
      end
    end
  end

`ifdef DDS_SWEEP_CNT_EN
  logic [15:0] cnt_q;
  logic        pass_done;

  assign pass_done = (state == RUN) && expire && !bus.abort && at_stop;

  always_ff @(posedge clock) begin
    if (rst || cfg_load) cnt_q <= '0;
    else if (pass_done)  cnt_q <= cnt_q + 16'd1;
  end

  assign bus.sweep_cnt = cnt_q;
`endif

  assign bus.fre_word    = fre_q;
  assign bus.dds_en      = (state == RUN);
  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == DONE);
  assign bus.step_strobe = strobe_q;
  assign bus.state       = state;
endmodule
